// File: rtl/bch_enc_sched.sv
// Round-robin sequencer sharing one serial BCH(63,56) LFSR engine between two requesters.
// Shifts {HDR, msg} MSB-first into the engine, then returns {HDR, msg, parity}.
`timescale 1ns/1ps
module bch_enc_sched #(
    parameter int unsigned MSG_W  = 32,
    parameter logic [23:0] HDR    = 24'h555555,
    parameter int unsigned INFO_W = 56,
    parameter int unsigned PAR_W  = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic [MSG_W-1:0]          req0_msg,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [MSG_W-1:0]          req1_msg,
    output logic                      req1_ready,
    output logic                      eng_clr,
    output logic                      eng_shift,
    output logic                      eng_bit,
    input  logic [PAR_W-1:0]          eng_parity,
    output logic                      cw_valid,
    output logic [INFO_W+PAR_W-1:0]   cw_data,
    output logic                      cw_id,
    input  logic                      cw_ready,
    output logic                      busy
);

    typedef enum logic [2:0] {StIdle, StLoad, StShift, StCapture, StOut} state_e;

    state_e                    state_q, state_d;
    logic                      last_q, last_d;
    logic [INFO_W-1:0]         shreg_q, shreg_d;
    logic [INFO_W-1:0]         info_q, info_d;
    logic [5:0]                cnt_q, cnt_d;
    logic [INFO_W+PAR_W-1:0]   cw_data_q, cw_data_d;
    logic                      cw_id_q, cw_id_d;
    logic                      grant;
    logic                      idle;

    assign idle = (state_q == StIdle);

    // Contention goes to whoever was not served last; last_q resets to 1 so req0 wins first.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = idle & ~grant & req0_valid;
    assign req1_ready = idle &  grant & req1_valid;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        shreg_d   = shreg_q;
        info_d    = info_q;
        cnt_d     = cnt_q;
        cw_data_d = cw_data_q;
        cw_id_d   = cw_id_q;
        case (state_q)
            StIdle: begin
                if (req0_ready || req1_ready) begin
                    shreg_d = {HDR, (grant ? req1_msg : req0_msg)};
                    info_d  = {HDR, (grant ? req1_msg : req0_msg)};
                    cw_id_d = grant;
                    last_d  = grant;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = 6'(INFO_W - 1);
                state_d = StShift;
            end
            StShift: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == 6'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            StCapture: begin
                cw_data_d = {info_q, eng_parity};
                state_d   = StOut;
            end
            StOut: begin
                if (cw_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            last_q    <= 1'b1;
            shreg_q   <= '0;
            info_q    <= '0;
            cnt_q     <= '0;
            cw_data_q <= '0;
            cw_id_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            shreg_q   <= shreg_d;
            info_q    <= info_d;
            cnt_q     <= cnt_d;
            cw_data_q <= cw_data_d;
            cw_id_q   <= cw_id_d;
        end
    end

    assign eng_clr   = (state_q == StLoad);
    assign eng_shift = (state_q == StShift);
    assign eng_bit   = eng_shift & shreg_q[INFO_W-1];
    assign cw_valid  = (state_q == StOut);
    assign busy      = ~idle;
    assign cw_data   = cw_data_q;
    assign cw_id     = cw_id_q;

endmodule

// File: tb/tb_bch_enc_sched.sv
// Directed + randomized bench for bch_enc_sched with an LFSR engine model and a
// polynomial-division golden parity.
`timescale 1ns/1ps
module tb_bch_enc_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_msg, req1_msg;
    logic        req0_ready, req1_ready;
    logic        eng_clr, eng_shift, eng_bit;
    logic [6:0]  eng_parity;
    logic        cw_valid;
    logic [62:0] cw_data;
    logic        cw_id;
    logic        cw_ready;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic last_id;

    always #5 clk = ~clk;

    bch_enc_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_msg   (req0_msg),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_msg   (req1_msg),
        .req1_ready (req1_ready),
        .eng_clr    (eng_clr),
        .eng_shift  (eng_shift),
        .eng_bit    (eng_bit),
        .eng_parity (eng_parity),
        .cw_valid   (cw_valid),
        .cw_data    (cw_data),
        .cw_id      (cw_id),
        .cw_ready   (cw_ready),
        .busy       (busy)
    );

    // Serial encoder engine, generator g(x) = x^7 + x^6 + x^2 + 1.
    logic [6:0] lfsr;
    logic       fb;
    assign fb = eng_bit ^ lfsr[6];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         lfsr <= '0;
        else if (eng_clr)   lfsr <= '0;
        else if (eng_shift) lfsr <= {lfsr[5:0], 1'b0} ^ (fb ? 7'h45 : 7'h00);
    end
    assign eng_parity = lfsr;

    // Golden parity: remainder of info(x) * x^7 divided by g(x).
    function automatic logic [6:0] bch_par(input logic [55:0] info);
        logic [62:0] r;
        r = {info, 7'b0};
        for (int i = 62; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'hC5;
        end
        return r[6:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_msg   = '0;
        req1_msg   = '0;
        cw_ready   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        last_id = 1'b1;
    endtask

    // One full transaction; entered and left at a negedge with DUT idle.
    task automatic txn(input logic v0, input logic v1, input logic [31:0] m0,
                       input logic [31:0] m1, input int hold, input bit poke1,
                       output longint t_acc);
        logic        exp_id;
        logic [55:0] info;
        logic [62:0] exp_cw;
        logic [55:0] bits;
        int          w, bad;
        req0_valid = v0; req0_msg = m0;
        req1_valid = v1; req1_msg = m1;
        cw_ready   = (hold == 0);
        exp_id     = (v0 && v1) ? ~last_id : v1;
        t_acc      = 0;
        #1;
        w = 0;
        while (!(req0_ready || req1_ready) && w < 300) begin
            @(negedge clk); #1; w++;
        end
        if (w >= 300) begin
            chk("grant_timeout", 64'(w), 64'd0);
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        t_acc = $time;
        chk("ready_id", {62'd0, req1_ready, req0_ready}, exp_id ? 64'd2 : 64'd1);
        last_id = exp_id;
        info    = {24'h555555, (exp_id ? m1 : m0)};
        exp_cw  = {info, bch_par(info)};
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("load", {59'd0, eng_clr, eng_shift, busy, req0_ready, req1_ready}, 64'b10100);
        bad = 0; bits = '0;
        for (int i = 0; i < 56; i++) begin
            @(negedge clk);
            bits = {bits[54:0], eng_bit};
            if (!eng_shift || eng_clr || req0_ready || req1_ready) bad++;
            if (poke1 && i == 10) req1_valid = 1'b1;
            if (poke1 && i == 30) req1_valid = 1'b0;
        end
        chk("shift_ctl", 64'(bad), 64'd0);
        chk("bit_stream", {8'd0, bits}, {8'd0, info});
        @(negedge clk);
        chk("capture", {61'd0, eng_shift, eng_clr, cw_valid}, 64'd0);
        @(negedge clk);
        chk("cw_valid", {63'd0, cw_valid}, 64'd1);
        chk("cw_data", {1'b0, cw_data}, {1'b0, exp_cw});
        chk("cw_id", {63'd0, cw_id}, {63'd0, exp_id});
        if (hold > 0) begin
            bad = 0;
            for (int k = 1; k < hold; k++) begin
                @(negedge clk);
                if (cw_valid !== 1'b1 || cw_data !== exp_cw || cw_id !== exp_id || !busy ||
                    req0_ready || req1_ready || eng_clr || eng_shift) bad++;
            end
            chk("hold_stable", 64'(bad), 64'd0);
            cw_ready = 1'b1;
        end
        @(negedge clk);
        chk("to_idle", {62'd0, busy, cw_valid}, 64'd0);
    endtask

    initial begin
        longint t0, t1;
        int     cnt;
        logic   v0, v1;
        // 1: quiet after reset
        do_reset();
        chk("reset_outs", {56'd0, req0_ready, req1_ready, eng_clr, eng_shift, eng_bit,
                           cw_valid, cw_id, busy}, 64'd0);
        chk("reset_cw_data", {1'b0, cw_data}, 64'd0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (eng_clr || eng_shift || busy || cw_valid || req0_ready || req1_ready) cnt++;
        end
        chk("idle_quiet", 64'(cnt), 64'd0);

        // 2: req0, all-zero message
        txn(1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b0, t0);

        // 3: both valid from reset, alternating, 60 cycles apart
        do_reset();
        txn(1'b1, 1'b1, $urandom, $urandom, 0, 1'b0, t0);
        for (int k = 0; k < 3; k++) begin
            txn(1'b1, 1'b1, $urandom, $urandom, 0, 1'b0, t1);
            chk("accept_spacing", 64'(t1 - t0), 64'd600);
            t0 = t1;
        end

        // 4: downstream stall for 10 cycles
        txn(1'b0, 1'b1, 32'h0, $urandom, 10, 1'b0, t0);

        // 5: reset in the 20th SHIFT cycle
        req0_valid = 1'b1; req0_msg = $urandom;
        #1;
        cnt = 0;
        while (!req0_ready && cnt < 300) begin
            @(negedge clk); #1; cnt++;
        end
        chk("mid_reset_grant", {63'd0, req0_ready}, 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_reset_shifting", {63'd0, eng_shift}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outs", {58'd0, eng_shift, eng_clr, eng_bit, cw_valid, cw_id, busy},
            64'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        last_id = 1'b1;
        cnt = 0;
        repeat (70) begin
            @(negedge clk);
            if (cw_valid || busy) cnt++;
        end
        chk("no_partial_cw", 64'(cnt), 64'd0);
        txn(1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, t0);

        // 6: req1 pulse during SHIFT is ignored
        txn(1'b1, 1'b0, $urandom, $urandom, 0, 1'b1, t0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || cw_valid || req1_ready) cnt++;
        end
        chk("pulse_ignored", 64'(cnt), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 8; k++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            txn(v0, v1, $urandom, $urandom, int'($urandom_range(0, 4)), 1'b0, t0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bch_enc_sched.md
Name: bch_enc_sched

Overview:
Round-robin scheduler and sequencer that shares one serial BCH(63,56) LFSR encoder engine between two message requesters. It accepts a 32-bit message and forms the 56-bit info word {HDR, msg}. It clears the engine, shifts the info word into it MSB-first, one bit per cycle, captures the 7-bit parity, and returns the 63-bit codeword to the requester it serviced. It sits between the message sources and the encoder engine and replaces free-running, self-started encoding.

Parameters:
MSG_W, 32, message width per requester
HDR, 24'h555555, fixed header prepended to the message (MSB first)
INFO_W, 56, info bits shifted into the engine (24 + MSG_W)
PAR_W, 7, parity width returned by the engine

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
req0_valid  in  1  requester 0 has a message
req0_msg  in  32  requester 0 message; sampled only on handshake
req0_ready  out  1  requester 0 handshake accepted this cycle
req1_valid  in  1  requester 1 has a message
req1_msg  in  32  requester 1 message
req1_ready  out  1  requester 1 handshake accepted this cycle
eng_clr  out  1  one-cycle pulse; engine LFSR is set to 0 on this edge
eng_shift  out  1  engine advances LFSR by one step with eng_bit
eng_bit  out  1  info bit presented to the engine
eng_parity  in  7  engine LFSR state; valid the cycle after the last shift
cw_valid  out  1  codeword available
cw_data  out  63  {HDR, msg, parity}; parity in [6:0]
cw_id  out  1  requester that owns cw_data
cw_ready  in  1  downstream accepts the codeword
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. The round-robin pointer prefers req0.
  - All outputs are 0: ready, eng_*, cw_valid, cw_data, cw_id, busy.
  - Engine outputs drop immediately, including mid-SHIFT. A partial codeword is discarded and never emitted.
- States: IDLE -> LOAD -> SHIFT -> CAPTURE -> OUT -> IDLE.
- IDLE:
  - grant = req0 if only req0_valid; req1 if only req1_valid.
  - If both are valid, grant goes to the requester not served last.
  - reqK_ready = (state==IDLE) & grant==K & reqK_valid. This is combinational, so at most one ready is high per cycle.
  - On handshake: latch {HDR, msg} into a 56-bit shift register, latch cw_id, update the pointer, and go to LOAD.
  - Valid dropping before handshake is legal. Valid is ignored in all states other than IDLE.
- LOAD (1 cycle): eng_clr=1, eng_shift=0, count=INFO_W-1.
- SHIFT (56 cycles): eng_shift=1 and eng_bit=shreg[55]. The shift register shifts left and the count decrements. Go to CAPTURE when count==0, after exactly 56 shift cycles.
- CAPTURE (1 cycle): eng_shift=0; register cw_data={shreg_orig[55:0], eng_parity}, where the info bits are held in a separate copy.
- OUT: cw_valid=1. cw_data and cw_id are held stable until cw_ready=1. Go to IDLE on the cycle after the handshake; cw_valid is 0 in IDLE.
- Latency: handshake in cycle T, LOAD T+1, SHIFT T+2..T+57, CAPTURE T+58, cw_valid first high in T+59.
- Throughput: earliest next accept is T+60 with cw_ready tied high.
- eng_clr and eng_shift are never high in the same cycle. Both are 0 in IDLE and OUT.
- Widths: count is 6 bits; it never wraps because it leaves SHIFT at 0.

Test Plan:
1. Assert reset, release with no valids -> all outputs 0, busy=0, no eng_clr/eng_shift pulses over 100 cycles.
2. req0_valid with msg=32'h0 at T -> req0_ready=1 in T only; eng_clr=1 in T+1; eng_shift=1 for exactly 56 cycles (T+2..T+57); eng_bit sequence is 0,1 repeated 12 times, then 32 zeros; cw_valid at T+59 with cw_data[62:7]={24'h555555,32'h0}, cw_data[6:0] equal to the golden-model parity, cw_id=0.
3. req0_valid and req1_valid both held from reset, cw_ready=1 -> service order req0, req1, req0, req1; cw_id alternates; accepts 60 cycles apart.
4. Hold cw_ready=0 for 10 cycles in OUT -> cw_valid, cw_data and cw_id stable; busy=1; no reqK_ready; on cw_ready=1, IDLE the next cycle.
5. Assert rst_n=0 at the 20th SHIFT cycle -> eng_shift=0 immediately and no cw_valid. After release, req1 only with msg=32'hFFFFFFFF -> last 32 eng_bit values are 1, cw_id=1, cw_data[38:7]=32'hFFFFFFFF.
6. req1_valid pulses high while in SHIFT, then drops before IDLE -> it is ignored, with no req1_ready and no extra codeword.
